// File: rtl/muldiv_pkg.sv
`default_nettype none
// =============================================================================
// Module      : muldiv_pkg
// Description : Shared types and constants for the sequential mult/div unit.
// Revision    : 1.0 - initial release
// =============================================================================
package muldiv_pkg;

    localparam int MULDIV_ITER = 32;

    typedef enum logic [1:0] {
        MULT  = 2'b00,
        MULTU = 2'b01,
        DIV   = 2'b10,
        DIVU  = 2'b11
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10
    } muldiv_state_e;

    function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_step.sv
`default_nettype none
// =============================================================================
// Module      : muldiv_step
// Description : One combinational shift-add (multiply) or restoring
//               shift-subtract (divide) iteration. The divide arm exists
//               only when MULDIV_SEQ_DIV_EN is defined.
// Revision    : 1.0 - initial release
// =============================================================================
module muldiv_step (
`ifdef MULDIV_SEQ_DIV_EN
    input  logic        is_div,
`endif
    input  logic [31:0] hi_in,
    input  logic [31:0] lo_in,
    input  logic [31:0] m,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out
);

    logic [32:0] w_sum;
`ifdef MULDIV_SEQ_DIV_EN
    logic [32:0] w_shifted;
    logic        w_ge;
`endif

    always_comb begin
        // Multiply: {hi,lo} is the product/multiplier pair shifted right each step
        w_sum  = {1'b0, hi_in} + {1'b0, (lo_in[0] ? m : 32'd0)};
        hi_out = w_sum[32:1];
        lo_out = {w_sum[0], lo_in[31:1]};
`ifdef MULDIV_SEQ_DIV_EN
        w_shifted = {hi_in, lo_in[31]};
        w_ge      = (w_shifted >= {1'b0, m});
        if (is_div) begin
            hi_out = w_ge ? (w_shifted[31:0] - m) : w_shifted[31:0];
            lo_out = {lo_in[30:0], w_ge};
        end
`endif
    end

endmodule
`default_nettype wire

// File: rtl/muldiv_seq.sv
`default_nettype none
// =============================================================================
// Module      : muldiv_seq
// Description : Iterative 32x32 multiply / divide unit with HI/LO registers.
//               Divide support is enabled by defining MULDIV_SEQ_DIV_EN.
// Revision    : 1.0 - initial release
// =============================================================================
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int ITER = MULDIV_ITER
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        rd_hi_req,
    input  logic        rd_lo_req,
    input  logic        wr_hi,
    input  logic        wr_lo,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        stall,
    output logic        done,
    output logic        div_by_zero,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [5:0] C_LAST_STEP = 6'(ITER - 1);

    muldiv_state_e state_q, state_d;
    logic [5:0]    cnt_q, cnt_d;
    logic [31:0]   acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d, m_q, m_d;
    logic [31:0]   hi_q, hi_d, lo_q, lo_d;
    logic          neg_lo_q, neg_lo_d, done_q, done_d;
    logic [31:0]   w_step_hi, w_step_lo;
    logic [63:0]   w_prod;
    logic          w_signed_op, w_start_ok;
`ifdef MULDIV_SEQ_DIV_EN
    logic          is_div_q, is_div_d, neg_hi_q, neg_hi_d, bz_q, bz_d, dbz_q, dbz_d;
`endif

    assign w_signed_op = (muldiv_op_e'(op) == MULT) || (muldiv_op_e'(op) == DIV);
`ifdef MULDIV_SEQ_DIV_EN
    assign w_start_ok  = start && (state_q == IDLE);
`else
    assign w_start_ok  = start && (state_q == IDLE) && !op[1];
`endif

    muldiv_step u_step (
`ifdef MULDIV_SEQ_DIV_EN
        .is_div (is_div_q),
`endif
        .hi_in  (acc_hi_q),
        .lo_in  (acc_lo_q),
        .m      (m_q),
        .hi_out (w_step_hi),
        .lo_out (w_step_lo)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (w_start_ok) state_d = RUN;
            RUN:     if (cnt_q == C_LAST_STEP) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy  = (state_q != IDLE);
        stall = busy && (start || rd_hi_req || rd_lo_req || wr_hi || wr_lo);
    end

    always_comb begin
        cnt_d    = cnt_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        m_d      = m_q;
        neg_lo_d = neg_lo_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        w_prod   = {acc_hi_q, acc_lo_q};
`ifdef MULDIV_SEQ_DIV_EN
        is_div_d = is_div_q;
        neg_hi_d = neg_hi_q;
        bz_d     = bz_q;
        dbz_d    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (wr_hi) hi_d = wdata;
                if (wr_lo) lo_d = wdata;
                // Both ops iterate on magnitudes; signs are restored in FIX
                if (w_start_ok) begin
                    cnt_d    = '0;
                    acc_hi_d = '0;
                    acc_lo_d = abs32(a, w_signed_op);
                    m_d      = abs32(b, w_signed_op);
                    neg_lo_d = w_signed_op && (a[31] ^ b[31]);
`ifdef MULDIV_SEQ_DIV_EN
                    is_div_d = op[1];
                    neg_hi_d = w_signed_op && a[31];
                    bz_d     = (b == 32'd0);
`endif
                end
            end
            RUN: begin
                acc_hi_d = w_step_hi;
                acc_lo_d = w_step_lo;
                cnt_d    = cnt_q + 6'd1;
            end
            FIX: begin
                done_d = 1'b1;
                if (neg_lo_q) w_prod = ~{acc_hi_q, acc_lo_q} + 64'd1;
`ifdef MULDIV_SEQ_DIV_EN
                if (is_div_q) begin
                    lo_d  = neg_lo_q ? (~acc_lo_q + 32'd1) : acc_lo_q;
                    hi_d  = neg_hi_q ? (~acc_hi_q + 32'd1) : acc_hi_q;
                    // Divide by zero leaves |a| in the remainder, so hi already equals a
                    if (bz_q) lo_d = 32'hFFFF_FFFF;
                    dbz_d = bz_q;
                end else
`endif
                begin
                    hi_d = w_prod[63:32];
                    lo_d = w_prod[31:0];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            m_q      <= '0;
            neg_lo_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
`ifdef MULDIV_SEQ_DIV_EN
            is_div_q <= 1'b0;
            neg_hi_q <= 1'b0;
            bz_q     <= 1'b0;
            dbz_q    <= 1'b0;
`endif
        end else begin
            cnt_q    <= cnt_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            m_q      <= m_d;
            neg_lo_q <= neg_lo_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
`ifdef MULDIV_SEQ_DIV_EN
            is_div_q <= is_div_d;
            neg_hi_q <= neg_hi_d;
            bz_q     <= bz_d;
            dbz_q    <= dbz_d;
`endif
        end
    end

    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
`ifdef MULDIV_SEQ_DIV_EN
    assign div_by_zero = dbz_q;
`else
    assign div_by_zero = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_muldiv_seq.sv
`default_nettype none
// =============================================================================
// Module      : tb_muldiv_seq
// Description : Self-checking bench for muldiv_seq (vector table plus
//               hand-written timing sequences); follows MULDIV_SEQ_DIV_EN.
// Revision    : 1.0 - initial release
// =============================================================================
module tb_muldiv_seq;

    localparam logic [1:0] C_MULT  = 2'b00;
    localparam logic [1:0] C_MULTU = 2'b01;
    localparam logic [1:0] C_DIV   = 2'b10;
    localparam logic [1:0] C_DIVU  = 2'b11;

    logic        clk = 1'b0;
    logic        rst, start, rd_hi_req, rd_lo_req, wr_hi, wr_lo;
    logic [1:0]  op;
    logic [31:0] a, b, wdata;
    logic        busy, stall, done, div_by_zero;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;
    logic [31:0] model_hi = '0;
    logic [31:0] model_lo = '0;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } vec_t;

    vec_t vecs[12];

    muldiv_seq dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .rd_hi_req   (rd_hi_req),
        .rd_lo_req   (rd_lo_req),
        .wr_hi       (wr_hi),
        .wr_lo       (wr_lo),
        .wdata       (wdata),
        .busy        (busy),
        .stall       (stall),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // From cycle 1 of an operation, step to cycle 34 counting cycles where busy/done misbehave
    task automatic run_to_done(output int bad);
        bad = 0;
        for (int c = 1; c <= 33; c++) begin
            if (busy !== 1'b1 || done !== 1'b0) bad++;
            tick();
        end
    endtask

    task automatic launch(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv);
        start = 1'b1; op = o; a = av; b = bv;
        tick();
        start = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int  bad;
        logic accept;
        accept = 1'b1;
`ifndef MULDIV_SEQ_DIV_EN
        if (v.op[1]) accept = 1'b0;
`endif
        launch(v.op, v.a, v.b);
        if (accept) begin
            run_to_done(bad);
            chk({v.name, " busy window"}, 64'(bad), 64'd0);
            chk({v.name, " done"}, {63'd0, done}, 64'd1);
            chk({v.name, " busy@34"}, {63'd0, busy}, 64'd0);
            chk({v.name, " hi"}, {32'd0, hi}, {32'd0, v.hi});
            chk({v.name, " lo"}, {32'd0, lo}, {32'd0, v.lo});
            chk({v.name, " dbz"}, {63'd0, div_by_zero}, {63'd0, v.dbz});
            model_hi = v.hi;
            model_lo = v.lo;
        end else begin
            bad = 0;
            for (int c = 1; c <= 34; c++) begin
                if (busy !== 1'b0 || done !== 1'b0 || div_by_zero !== 1'b0) bad++;
                tick();
            end
            chk({v.name, " ignored"}, 64'(bad), 64'd0);
            chk({v.name, " hi held"}, {32'd0, hi}, {32'd0, model_hi});
            chk({v.name, " lo held"}, {32'd0, lo}, {32'd0, model_lo});
        end
        tick();
    endtask

    initial begin
        int bad;
        vecs[0]  = '{"mult neg*pos",    C_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
        vecs[1]  = '{"multu max*max",   C_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
        vecs[2]  = '{"mult min*min",    C_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
        vecs[3]  = '{"multu x*0",       C_MULTU, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0};
        vecs[4]  = '{"mult pos*neg",    C_MULT,  32'h0001_0000, 32'hFFFF_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
        vecs[5]  = '{"multu 2^16*2^16", C_MULTU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 1'b0};
        vecs[6]  = '{"div -7/2",        C_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        vecs[7]  = '{"divu 100/0",      C_DIVU,  32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF, 1'b1};
        vecs[8]  = '{"div min/-1",      C_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
        vecs[9]  = '{"divu 100/7",      C_DIVU,  32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, 1'b0};
        vecs[10] = '{"div 7/-2",        C_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
        vecs[11] = '{"div -7/0",        C_DIV,   32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1};

        rst = 1'b1; start = 1'b0; op = C_MULT; a = '0; b = '0;
        rd_hi_req = 1'b0; rd_lo_req = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0; wdata = '0;
        tick(); tick();
        rst = 1'b0;
        tick();

        chk("reset busy",  {63'd0, busy},  64'd0);
        chk("reset stall", {63'd0, stall}, 64'd0);
        chk("reset done",  {63'd0, done},  64'd0);
        chk("reset dbz",   {63'd0, div_by_zero}, 64'd0);
        chk("reset hi",    {32'd0, hi}, 64'd0);
        chk("reset lo",    {32'd0, lo}, 64'd0);

        // mthi / mtlo in IDLE
        wr_hi = 1'b1; wdata = 32'h1234_5678;
        tick();
        wr_hi = 1'b0;
        chk("mthi idle", {32'd0, hi}, 64'h0000_0000_1234_5678);
        wr_lo = 1'b1; wdata = 32'hCAFE_0001;
        tick();
        wr_lo = 1'b0;
        chk("mtlo idle", {32'd0, lo}, 64'h0000_0000_CAFE_0001);
        model_hi = 32'h1234_5678;
        model_lo = 32'hCAFE_0001;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Stall window, mthi and start while busy are blocked
        launch(C_MULT, 32'd3, 32'd5);
        bad = 0;
        for (int c = 1; c <= 33; c++) begin
            wr_hi = (c == 3);
            wdata = 32'hDEAD_BEEF;
            start = (c == 10);
            op    = C_MULTU; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
            if (c == 5) rd_lo_req = 1'b1;
            #1;
            if (stall !== ((c >= 5) || c == 3 || c == 10)) bad++;
            if (c == 4 && hi !== model_hi) bad++;
            tick();
        end
        wr_hi = 1'b0; start = 1'b0;
        chk("stall window", 64'(bad), 64'd0);
        chk("stall@34", {63'd0, stall}, 64'd0);
        chk("stall done", {63'd0, done}, 64'd1);
        chk("stall lo", {32'd0, lo}, 64'd15);
        chk("stall hi", {32'd0, hi}, 64'd0);
        rd_lo_req = 1'b0;
        tick();
        chk("no restart busy", {63'd0, busy}, 64'd0);
        chk("done one cycle",  {63'd0, done}, 64'd0);
        model_hi = 32'd0; model_lo = 32'd15;

        // Back-to-back: start accepted in the done cycle
        launch(C_MULT, 32'd2, 32'd3);
        run_to_done(bad);
        chk("b2b first window", 64'(bad), 64'd0);
        chk("b2b first lo", {32'd0, lo}, 64'd6);
        start = 1'b1; op = C_MULTU; a = 32'd10; b = 32'd10;
        tick();
        start = 1'b0;
        chk("b2b second busy", {63'd0, busy}, 64'd1);
        chk("b2b lo held", {32'd0, lo}, 64'd6);
        run_to_done(bad);
        chk("b2b second window", 64'(bad), 64'd0);
        chk("b2b second done", {63'd0, done}, 64'd1);
        chk("b2b second lo", {32'd0, lo}, 64'd100);
        tick();

        // mtlo together with start: both act, FIX overwrites
        wr_lo = 1'b1; wdata = 32'h0000_AAAA;
        launch(C_MULT, 32'd4, 32'd4);
        wr_lo = 1'b0;
        chk("mtlo+start lo", {32'd0, lo}, 64'h0000_AAAA);
        run_to_done(bad);
        chk("mtlo+start window", 64'(bad), 64'd0);
        chk("mtlo+start result", {32'd0, lo}, 64'd16);
        tick();

        // Reset in cycle 10 of a multiply
        launch(C_MULT, 32'd3, 32'd5);
        for (int c = 1; c < 10; c++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrun rst busy", {63'd0, busy}, 64'd0);
        chk("midrun rst hi", {32'd0, hi}, 64'd0);
        chk("midrun rst lo", {32'd0, lo}, 64'd0);
        bad = 0;
        for (int c = 0; c < 40; c++) begin
            if (done !== 1'b0 || busy !== 1'b0) bad++;
            tick();
        end
        chk("midrun rst no done", 64'(bad), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 SHALL have ports, clock and reset first (name, direction, width, meaning):
- clk  in  1  clock
- rst  in  1  reset
- start  in  1  begin operation
- op  in  2  00 mult, 01 multu, 10 div, 11 divu
- a  in  32  rs operand
- b  in  32  rt operand
- rd_hi_req  in  1  mfhi request
- rd_lo_req  in  1  mflo request
- wr_hi  in  1  mthi
- wr_lo  in  1  mtlo
- wdata  in  32  mthi/mtlo data
- busy  out  1  operation in progress
- stall  out  1  hold fetch/execute
- done  out  1  one-cycle result-valid pulse
- div_by_zero  out  1  pulses with done
- hi  out  32  HI register
- lo  out  32  LO register
REQ-002 SHALL use one clock, clk; reset rst is synchronous and active-high.
REQ-003 SHALL have parameter ITER, default 32, meaning iteration count; only 32 is supported.

Function
REQ-004 SHALL implement states IDLE, RUN, FIX; busy = (state != IDLE).
REQ-005 IDLE: start=1 at an edge latches |a|, |b| (signed ops) or a, b (unsigned ops) and the result signs, clears the iteration counter, and moves to RUN.
REQ-006 RUN: one shift-add (mult) or shift-subtract restoring (div) step per cycle; after the 32nd step moves to FIX.
REQ-007 FIX: applies signs, writes hi/lo at its closing edge, moves to IDLE, and registers done=1 for exactly one cycle.
REQ-008 Timing (start high in cycle 0): busy high in cycles 1-33; done high and hi/lo valid in cycle 34.
REQ-009 Multiply SHALL write the 64-bit product as {hi,lo}; signed product is negated when sign(a)^sign(b).
REQ-010 Divide SHALL write quotient to lo and remainder to hi; quotient sign = sign(a)^sign(b); remainder sign = sign(a).
REQ-011 Divide with b=0 SHALL still take the full latency and SHALL write lo=32'hFFFFFFFF and hi=a, with div_by_zero=1 together with done.
REQ-012 Signed 32'h80000000 / 32'hFFFFFFFF SHALL give lo=32'h80000000, hi=0.
REQ-013 stall = busy & (start | rd_hi_req | rd_lo_req | wr_hi | wr_lo), combinational.
REQ-014 start, wr_hi and wr_lo SHALL be ignored while busy; hi/lo are unchanged during RUN/FIX.
REQ-015 In IDLE, wr_hi/wr_lo SHALL load wdata into hi/lo at the next edge. If start is asserted in the same cycle, both take effect; the later FIX overwrites.
REQ-016 start in the cycle where done=1 SHALL be accepted; hi/lo hold the previous result until the new FIX.

Reset
REQ-017 rst=1 at any edge, including mid-RUN/FIX, SHALL force IDLE, hi=0, lo=0, done=0, div_by_zero=0, and clear the counter; busy and stall are 0 in the following cycle.

Configuration
REQ-018 Macro MULDIV_SEQ_DIV_EN SHALL control divide support:
- Defined: divide per REQ-010 to REQ-012.
- Undefined: start with op 10/11 is ignored (state stays IDLE, hi/lo unchanged, no done), div_by_zero is tied to 0, and the divide datapath is absent.

Structure
REQ-019 Package muldiv_pkg SHALL hold the op enum (MULT, MULTU, DIV, DIVU), the state enum (IDLE, RUN, FIX) and the constant MULDIV_ITER=32.
REQ-020 Sub-module muldiv_step SHALL be a combinational single-iteration shift-add / shift-subtract step; muldiv_seq holds all registers and the FSM.

Verification
REQ-021 mult a=32'hFFFFFFFD, b=7 -> cycle 34: done=1, hi=32'hFFFFFFFF, lo=32'hFFFFFFEB.
REQ-022 multu a=b=32'hFFFFFFFF -> hi=32'hFFFFFFFE, lo=32'h00000001.
REQ-023 div a=32'hFFFFFFF9 (-7), b=2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF; divu a=100, b=0 -> lo=32'hFFFFFFFF, hi=32'h00000064, div_by_zero=1.
REQ-024 rd_lo_req held from cycle 5 -> stall=1 in cycles 5-33, stall=0 in cycle 34 with lo valid.
REQ-025 rst asserted in cycle 10 of a mult -> cycle 11: busy=0, hi=lo=0, and no done pulse ever occurs.
REQ-026 wr_hi with wdata=32'h12345678 in IDLE -> hi=32'h12345678 next cycle; the same wr_hi while busy -> stall=1, hi unchanged.
